// File: rtl/key_event_gen.sv
// Multi-channel key-event generator: per-channel synchroniser, debouncer and
// single-cycle press/release/auto-repeat event outputs for the front panel.
module key_event_gen #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_PER  = 4,
  localparam int IW         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] key_in,
  input  logic [CH-1:0] repeat_en,
  output logic [CH-1:0] key_state,
  output logic [CH-1:0] press_pulse,
  output logic [CH-1:0] repeat_flag,
  output logic [CH-1:0] release_pulse,
  output logic          any_press,
  output logic [IW-1:0] press_idx
);

  localparam int DW   = $clog2(DEBOUNCE + 1);
  localparam int HMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DLY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PER - 1);

  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CH-1:0] sync_lvl;
  logic [DW-1:0] db_cnt [CH];
  logic [HW-1:0] hold_cnt [CH];
  logic [CH-1:0] in_repeat;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] fire;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= key_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // A repeat is never allowed on the edge that accepts a release.
  always_comb begin
    rise = '0;
    fall = '0;
    fire = '0;
    for (int i = 0; i < CH; i++) begin
      rise[i] = !key_state[i] && sync_lvl[i] && (db_cnt[i] == DB_LAST);
      fall[i] = key_state[i] && !sync_lvl[i] && (db_cnt[i] == DB_LAST);
      fire[i] = key_state[i] && repeat_en[i] && !fall[i] &&
                (in_repeat[i] ? (hold_cnt[i] == PER_LAST) : (hold_cnt[i] == DLY_LAST));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_state     <= '0;
      press_pulse   <= '0;
      repeat_flag   <= '0;
      release_pulse <= '0;
      in_repeat     <= '0;
      for (int i = 0; i < CH; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      press_pulse   <= rise | fire;
      repeat_flag   <= fire;
      release_pulse <= fall;
      for (int i = 0; i < CH; i++) begin
        if (sync_lvl[i] == key_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]    <= '0;
          key_state[i] <= sync_lvl[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end

        // Hold counter restarts whenever the key is up, repeat is off or releasing.
        if (!key_state[i] || !repeat_en[i] || fall[i]) begin
          hold_cnt[i]  <= '0;
          in_repeat[i] <= 1'b0;
        end else if (fire[i]) begin
          hold_cnt[i]  <= '0;
          in_repeat[i] <= 1'b1;
        end else begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    any_press = |press_pulse;
    press_idx = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (press_pulse[i]) press_idx = IW'(i);
    end
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Scoreboard bench for key_event_gen: directed key scenarios push expected
// events into a queue; a monitor pops and compares each event the DUT shows.
module tb_key_event_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_in;
  logic [3:0] repeat_en;
  logic [3:0] key_state;
  logic [3:0] press_pulse;
  logic [3:0] repeat_flag;
  logic [3:0] release_pulse;
  logic       any_press;
  logic [1:0] press_idx;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] flag;
    logic [3:0] rel;
    logic [1:0] idx;
  } ev_t;

  ev_t sbq[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_bad = 0;

  key_event_gen dut (
    .clk           (clk),
    .reset         (reset),
    .key_in        (key_in),
    .repeat_en     (repeat_en),
    .key_state     (key_state),
    .press_pulse   (press_pulse),
    .repeat_flag   (repeat_flag),
    .release_pulse (release_pulse),
    .any_press     (any_press),
    .press_idx     (press_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] f,
                         input logic [3:0] r, input logic [1:0] idx);
    ev_t e;
    e.cyc = c; e.press = p; e.flag = f; e.rel = r; e.idx = idx;
    sbq.push_back(e);
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_idle_zero(input string tag);
    check_output({tag, " key_state"}, int'(key_state), 0);
    check_output({tag, " press_pulse"}, int'(press_pulse), 0);
    check_output({tag, " repeat_flag"}, int'(repeat_flag), 0);
    check_output({tag, " release_pulse"}, int'(release_pulse), 0);
    check_output({tag, " any_press"}, int'(any_press), 0);
    check_output({tag, " press_idx"}, int'(press_idx), 0);
  endtask

  // Monitor: every cycle carrying an event must match the next expected event.
  always @(negedge clk) begin
    if ((press_pulse | release_pulse) != 4'b0) begin
      if (sbq.size() == 0) begin
        check_output("unexpected event press", int'(press_pulse), 0);
        check_output("unexpected event release", int'(release_pulse), 0);
      end else begin
        ev_t e;
        e = sbq.pop_front();
        check_output("event cycle", cyc, e.cyc);
        check_output("press_pulse", int'(press_pulse), int'(e.press));
        check_output("repeat_flag", int'(repeat_flag), int'(e.flag));
        check_output("release_pulse", int'(release_pulse), int'(e.rel));
        check_output("any_press", int'(any_press), int'(e.press != 4'b0));
        check_output("press_idx", int'(press_idx), int'(e.idx));
      end
    end
  end

  task automatic apply_stimulus();
    reset = 1'b1; key_in = '0; repeat_en = '0;
    to_cyc(2);
    reset = 1'b0;
    check_idle_zero("reset");

    // Clean press on ch0, released 3 cycles after acceptance.
    to_cyc(4);
    push_ev(10, 4'b0001, 4'b0000, 4'b0000, 2'd0);
    push_ev(19, 4'b0000, 4'b0000, 4'b0001, 2'd0);
    key_in[0] = 1'b1;
    to_cyc(7);
    check_output("ch0 key_state before accept", int'(key_state), 0);
    to_cyc(10);
    check_output("ch0 key_state at accept", int'(key_state), 1);
    to_cyc(13);
    key_in[0] = 1'b0;
    to_cyc(20);
    check_output("ch0 key_state after release", int'(key_state), 0);

    // Bouncing ch1: 1,0,1,1,0 then stable 1 from cycle 27.
    to_cyc(22);
    push_ev(33, 4'b0010, 4'b0000, 4'b0000, 2'd1);
    push_ev(46, 4'b0000, 4'b0000, 4'b0010, 2'd0);
    key_in[1] = 1'b1; to_cyc(23);
    key_in[1] = 1'b0; to_cyc(24);
    key_in[1] = 1'b1; to_cyc(25);
    key_in[1] = 1'b1; to_cyc(26);
    key_in[1] = 1'b0; to_cyc(27);
    key_in[1] = 1'b1;
    to_cyc(40);
    key_in[1] = 1'b0;

    // Auto-repeat on ch2 (P = 56) with a 5-cycle enable gap, R = 79.
    to_cyc(48);
    repeat_en[2] = 1'b1;
    to_cyc(50);
    push_ev(56, 4'b0100, 4'b0000, 4'b0000, 2'd2);
    push_ev(64, 4'b0100, 4'b0100, 4'b0000, 2'd2);
    push_ev(68, 4'b0100, 4'b0100, 4'b0000, 2'd2);
    push_ev(72, 4'b0100, 4'b0100, 4'b0000, 2'd2);
    push_ev(87, 4'b0100, 4'b0100, 4'b0000, 2'd2);
    push_ev(91, 4'b0100, 4'b0100, 4'b0000, 2'd2);
    push_ev(95, 4'b0000, 4'b0000, 4'b0100, 2'd0);
    key_in[2] = 1'b1;
    to_cyc(74);
    repeat_en[2] = 1'b0;
    to_cyc(79);
    repeat_en[2] = 1'b1;
    to_cyc(89);
    key_in[2] = 1'b0;
    to_cyc(97);
    repeat_en[2] = 1'b0;

    // Simultaneous press on ch1 and ch3.
    to_cyc(100);
    push_ev(106, 4'b1010, 4'b0000, 4'b0000, 2'd1);
    push_ev(116, 4'b0000, 4'b0000, 4'b1010, 2'd0);
    key_in[1] = 1'b1; key_in[3] = 1'b1;
    to_cyc(110);
    key_in[1] = 1'b0; key_in[3] = 1'b0;

    // Reset pulse mid-repeat on ch2 (P = 128), key kept held through it.
    to_cyc(120);
    repeat_en[2] = 1'b1;
    to_cyc(122);
    push_ev(128, 4'b0100, 4'b0000, 4'b0000, 2'd2);
    push_ev(136, 4'b0100, 4'b0100, 4'b0000, 2'd2);
    push_ev(144, 4'b0100, 4'b0000, 4'b0000, 2'd2);
    push_ev(152, 4'b0000, 4'b0000, 4'b0100, 2'd0);
    key_in[2] = 1'b1;
    to_cyc(137);
    reset = 1'b1;
    to_cyc(138);
    reset = 1'b0;
    check_idle_zero("mid-repeat reset");
    to_cyc(146);
    key_in[2] = 1'b0;

    to_cyc(160);
    check_output("events left in scoreboard", sbq.size(), 0);
  endtask

  initial begin
    apply_stimulus();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
